// File: rtl/arcade_input_pkg.sv
// Arcade input controller shared definitions.
// Holds the coin FSM state type, the bit positions of each button in a
// player's joy_in word, the loader index that targets the DIP switch banks,
// and the helper that maps a registered joy byte onto the seven non-coin
// ctrl_out bits.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } coin_state_t;

    // Bit positions inside a player's joy_in byte (active high)
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_B1    = 4;
    localparam int JOY_B2    = 5;
    localparam int JOY_START = 6;
    localparam int JOY_COIN  = 7;

    localparam logic [7:0] DSW_IOCTL_INDEX = 8'd254;

    // Returns {start, b2, b1, down, right, left, up}. With socd set, opposing
    // directions pressed together cancel to neutral.
    function automatic logic [6:0] joy_to_ctrl(input logic [7:0] j, input logic socd);
        logic lr_clash;
        logic ud_clash;
        lr_clash = socd & j[JOY_LEFT] & j[JOY_RIGHT];
        ud_clash = socd & j[JOY_UP] & j[JOY_DOWN];
        return {j[JOY_START], j[JOY_B2], j[JOY_B1],
                j[JOY_DOWN]  & ~ud_clash,
                j[JOY_RIGHT] & ~lr_clash,
                j[JOY_LEFT]  & ~lr_clash,
                j[JOY_UP]    & ~ud_clash};
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// coin_pulser: one player's coin pulse shaper.
// A rising coin edge (while not locked out) produces a pulse of exactly
// COIN_PULSE cycles, followed by a holdoff of at least COIN_HOLDOFF cycles
// that only ends once the coin input has been released.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   sample_vld_i coin_i holds a real sample (low on the first cycle after reset)
//   coin_i       registered coin input
//   lockout_i    blocks new pulses from starting
//   pulse_o      coin output, high while in PULSE
//   start_o      high in the cycle the FSM commits to IDLE->PULSE
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter logic [15:0] COIN_PULSE   = 16'd4800,
    parameter logic [15:0] COIN_HOLDOFF = 16'd4800
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_vld_i,
    input  logic coin_i,
    input  logic lockout_i,
    output logic pulse_o,
    output logic start_o
);

    coin_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    // Set only after a genuine low sample, so a coin held through reset
    // release (or through a locked-out edge) must be released before it counts.
    logic        armed_q, armed_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_o = 1'b0;
        armed_d = sample_vld_i & ~coin_i;
        case (state_q)
            IDLE: begin
                if (coin_i && armed_q && !lockout_i) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    start_o = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q >= COIN_PULSE - 16'd1) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLDOFF: begin
                if (cnt_q >= COIN_HOLDOFF && !coin_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 16'hFFFF) begin
                    // Saturate so a long-held coin cannot wrap the count
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse_o = (state_q == PULSE);

endmodule

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: player input conditioning and DIP switch storage.
// joy_in is registered once, remapped, and registered again onto ctrl_out.
// Each player's coin goes through a coin_pulser; coin_count totals pulses.
// DIP banks are written by the loader at index 254.
// Optional feature: define INPUT_SOCD_EN to neutralise opposing directions
// (left+right, up+down) pressed together; otherwise directions pass through.
// Ports:
//   clk_sys      system clock
//   reset_n      synchronous active-low reset
//   joy_in       16 bits per player, low byte used (right,left,down,up,b1,b2,start,coin)
//   coin_lockout blocks new coin pulses
//   ioctl_*      loader write port (wr strobe, index, byte address, data)
//   ctrl_out     8 bits per player {coin,start,b2,b1,down,right,left,up}
//   dsw_out      DIP banks, bank b at [8b+7:8b]
//   dsw_valid    set once bank 0 has been written
//   coin_count   wrapping total of coin pulses issued
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int                     NUM_PLAYERS  = 2,
    parameter int                     DSW_BANKS    = 1,
    parameter logic [8*DSW_BANKS-1:0] DSW_DEFAULT  = '1,
    parameter logic [15:0]            COIN_PULSE   = 16'd4800,
    parameter logic [15:0]            COIN_HOLDOFF = 16'd4800,
    parameter bit                     ACTIVE_LOW   = 1'b0
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [16*NUM_PLAYERS-1:0] joy_in,
    input  logic                      coin_lockout,
    input  logic                      ioctl_wr,
    input  logic [7:0]                ioctl_index,
    input  logic [26:0]               ioctl_addr,
    input  logic [15:0]               ioctl_dout,
    output logic [8*NUM_PLAYERS-1:0]  ctrl_out,
    output logic [8*DSW_BANKS-1:0]    dsw_out,
    output logic                      dsw_valid,
    output logic [7:0]                coin_count
);

`ifdef INPUT_SOCD_EN
    localparam bit SOCD_EN = 1'b1;
`else
    localparam bit SOCD_EN = 1'b0;
`endif

    localparam logic [3:0] BANKS_L = 4'(DSW_BANKS);

    logic [8*NUM_PLAYERS-1:0] joy_d, joy_q;
    logic [7*NUM_PLAYERS-1:0] ctrl_d, ctrl_q;
    logic                     in_vld_q;
    logic [NUM_PLAYERS-1:0]   coin_pulse;
    logic [NUM_PLAYERS-1:0]   coin_start;
    logic [7:0]               coin_inc;
    logic [7:0]               count_d, count_q;
    logic [8*DSW_BANKS-1:0]   dsw_d, dsw_q;
    logic                     dsw_valid_d, dsw_valid_q;
    logic [8*NUM_PLAYERS-1:0] joy_hi_unused;
    logic                     unused_bits;

    genvar p;
    generate
        for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
            assign joy_d[8*p +: 8]         = joy_in[16*p +: 8];
            assign joy_hi_unused[8*p +: 8] = joy_in[16*p+8 +: 8];
            assign ctrl_d[7*p +: 7]        = joy_to_ctrl(joy_q[8*p +: 8], SOCD_EN);

            coin_pulser #(
                .COIN_PULSE   (COIN_PULSE),
                .COIN_HOLDOFF (COIN_HOLDOFF)
            ) u_coin (
                .clk_i        (clk_sys),
                .rst_ni       (reset_n),
                .sample_vld_i (in_vld_q),
                .coin_i       (joy_q[8*p + JOY_COIN]),
                .lockout_i    (coin_lockout),
                .pulse_o      (coin_pulse[p]),
                .start_o      (coin_start[p])
            );

            // Coin bit comes straight from the FSM state register, so it
            // lines up with the other bits two cycles after joy_in.
            assign ctrl_out[8*p +: 8] = {coin_pulse[p], ctrl_q[7*p +: 7]} ^ {8{ACTIVE_LOW}};
        end
    endgenerate

    assign unused_bits = ^{ioctl_addr[26:25], ioctl_dout[15:8], joy_hi_unused};

    always_comb begin
        coin_inc = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            coin_inc = coin_inc + {7'd0, coin_start[i]};
        end
        count_d = count_q + coin_inc;
    end

    always_comb begin
        dsw_d       = dsw_q;
        dsw_valid_d = dsw_valid_q;
        if (ioctl_wr && ioctl_index == DSW_IOCTL_INDEX &&
            ioctl_addr[24:3] == 22'd0 && {1'b0, ioctl_addr[2:0]} < BANKS_L) begin
            for (int b = 0; b < DSW_BANKS; b++) begin
                if (ioctl_addr[2:0] == 3'(b)) begin
                    dsw_d[8*b +: 8] = ioctl_dout[7:0];
                end
            end
            if (ioctl_addr[2:0] == 3'd0) begin
                dsw_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            joy_q       <= '0;
            ctrl_q      <= '0;
            in_vld_q    <= 1'b0;
            count_q     <= '0;
            dsw_q       <= DSW_DEFAULT;
            dsw_valid_q <= 1'b0;
        end else begin
            joy_q       <= joy_d;
            ctrl_q      <= ctrl_d;
            in_vld_q    <= 1'b1;
            count_q     <= count_d;
            dsw_q       <= dsw_d;
            dsw_valid_q <= dsw_valid_d;
        end
    end

    assign dsw_out    = dsw_q;
    assign dsw_valid  = dsw_valid_q;
    assign coin_count = count_q;

endmodule
